// File: rtl/fsm_trans_monitor.sv
// Passive transition-coverage monitor for a small encoded FSM: records legal transitions seen,
// flags and counts illegal ones. Define FSM_MON_HIST_EN to add the last_trans history port.
module fsm_trans_monitor #(
    parameter int                              STATE_W     = 2,
    parameter int                              CNT_W       = 8,
    parameter logic [(1<<(2*STATE_W))-1:0]     LEGAL       = 16'h1842,
    parameter bit                              IGNORE_SELF = 1'b1
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               start,
    input  logic                               stop,
    input  logic                               clear,
    input  logic                               valid,
    input  logic [STATE_W-1:0]                 cur_state,
    input  logic [STATE_W-1:0]                 nxt_state,
    output logic [(1<<(2*STATE_W))-1:0]        hit,
    output logic                               illegal,
    output logic [CNT_W-1:0]                   illegal_cnt,
    output logic [CNT_W-1:0]                   trans_cnt,
    output logic                               all_hit,
    output logic                               busy
`ifdef FSM_MON_HIST_EN
    ,
    output logic [4*2*STATE_W-1:0]             last_trans
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [2*STATE_W-1:0] idx;
    logic                 is_self;
    logic                 rec;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // NOTE: state_nxt gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = RUN;
                RUN:     if (stop)  state_nxt = HOLD;
                HOLD:    if (start) state_nxt = RUN;
                default:            state_nxt = IDLE;
            endcase
        end
    end

    assign idx     = {cur_state, nxt_state};
    assign is_self = IGNORE_SELF && (cur_state == nxt_state);
    // A sample in the stop cycle still counts (state is RUN); clear discards it.
    assign rec     = (state == RUN) && valid && !clear && !is_self;

    // NOTE: every result register has an async reset; they are few and flat,
    // so there is no memory here that would argue for leaving them unreset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hit         <= '0;
            illegal     <= 1'b0;
            illegal_cnt <= '0;
            trans_cnt   <= '0;
        end else if (clear) begin
            hit         <= '0;
            illegal     <= 1'b0;
            illegal_cnt <= '0;
            trans_cnt   <= '0;
        end else if (rec) begin
            if (LEGAL[idx]) begin
                hit[idx] <= 1'b1;
                if (trans_cnt != CNT_MAX) trans_cnt <= trans_cnt + CNT_W'(1);
            end else begin
                illegal <= 1'b1;
                if (illegal_cnt != CNT_MAX) illegal_cnt <= illegal_cnt + CNT_W'(1);
            end
        end
    end

`ifdef FSM_MON_HIST_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)    last_trans <= '0;
        else if (clear)  last_trans <= '0;
        else if (rec)    last_trans <= {last_trans[3*2*STATE_W-1:0], idx};
    end
`endif

    // With LEGAL all-zero this reduces to 1, which is the intended behaviour.
    assign all_hit = ((hit & LEGAL) == LEGAL);
    assign busy    = (state == RUN);

endmodule

// File: tb/tb_fsm_trans_monitor.sv
// Scoreboard bench for fsm_trans_monitor: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_fsm_trans_monitor;

    logic        clock;
    logic        reset_n;
    logic        start, stop, clear, valid;
    logic [1:0]  cur_state, nxt_state;
    logic [15:0] hit;
    logic        illegal;
    logic [7:0]  illegal_cnt, trans_cnt;
    logic        all_hit, busy;
`ifdef FSM_MON_HIST_EN
    logic [15:0] last_trans;
`endif

    fsm_trans_monitor dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .stop        (stop),
        .clear       (clear),
        .valid       (valid),
        .cur_state   (cur_state),
        .nxt_state   (nxt_state),
        .hit         (hit),
        .illegal     (illegal),
        .illegal_cnt (illegal_cnt),
        .trans_cnt   (trans_cnt),
        .all_hit     (all_hit),
        .busy        (busy)
`ifdef FSM_MON_HIST_EN
        ,
        .last_trans  (last_trans)
`endif
    );

    typedef struct {
        string       name;
        logic [15:0] hit;
        logic        illegal;
        logic [7:0]  ill_cnt;
        logic [7:0]  trans_cnt;
        logic        all_hit;
        logic        busy;
        logic        chk_hist;
        logic [15:0] hist;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    endtask

    // Monitor: outputs only move at posedge or on async reset, so negedge is a stable point.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check({e.name, ".hit"},         32'(hit),         32'(e.hit));
                check({e.name, ".illegal"},     32'(illegal),     32'(e.illegal));
                check({e.name, ".illegal_cnt"}, 32'(illegal_cnt), 32'(e.ill_cnt));
                check({e.name, ".trans_cnt"},   32'(trans_cnt),   32'(e.trans_cnt));
                check({e.name, ".all_hit"},     32'(all_hit),     32'(e.all_hit));
                check({e.name, ".busy"},        32'(busy),        32'(e.busy));
`ifdef FSM_MON_HIST_EN
                if (e.chk_hist) check({e.name, ".last_trans"}, 32'(last_trans), 32'(e.hist));
`endif
            end
        end
    end

    task automatic step(input logic st, input logic sp, input logic cl, input logic v,
                        input logic [1:0] c, input logic [1:0] n);
        @(negedge clock);
        start = st; stop = sp; clear = cl; valid = v; cur_state = c; nxt_state = n;
        @(posedge clock);
        #1;
        start = 1'b0; stop = 1'b0; clear = 1'b0; valid = 1'b0;
    endtask

    task automatic exp_out(input string nm, input logic [15:0] h, input logic il,
                           input logic [7:0] ic, input logic [7:0] tc, input logic ah,
                           input logic b, input logic ch = 1'b0, input logic [15:0] hs = 16'h0);
        exp_t e;
        e.name = nm; e.hit = h; e.illegal = il; e.ill_cnt = ic; e.trans_cnt = tc;
        e.all_hit = ah; e.busy = b; e.chk_hist = ch; e.hist = hs;
        sb_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wait_cycles;
        reset_n = 1'b0;
        start = 1'b0; stop = 1'b0; clear = 1'b0; valid = 1'b0;
        cur_state = 2'd0; nxt_state = 2'd0;

        step(0, 0, 0, 0, 2'd0, 2'd0);
        exp_out("reset", 16'h0, 0, 8'd0, 8'd0, 0, 0, 1, 16'h0);
        @(negedge clock);
        reset_n = 1'b1;

        step(0, 0, 0, 1, 2'd0, 2'd1);
        exp_out("idle_no_start", 16'h0, 0, 8'd0, 8'd0, 0, 0, 1, 16'h0);

        step(1, 0, 0, 0, 2'd0, 2'd0);
        exp_out("start", 16'h0, 0, 8'd0, 8'd0, 0, 1);

        step(0, 0, 0, 1, 2'd0, 2'd1);
        exp_out("t01", 16'h0002, 0, 8'd0, 8'd1, 0, 1);
        step(0, 0, 0, 1, 2'd1, 2'd2);
        exp_out("t12", 16'h0042, 0, 8'd0, 8'd2, 0, 1);
        step(0, 0, 0, 1, 2'd2, 2'd3);
        exp_out("t23", 16'h0842, 0, 8'd0, 8'd3, 0, 1);
        step(0, 0, 0, 1, 2'd3, 2'd0);
        exp_out("t30", 16'h1842, 0, 8'd0, 8'd4, 1, 1, 1, 16'h16BC);

        step(0, 0, 0, 1, 2'd0, 2'd2);
        exp_out("ill02", 16'h1842, 1, 8'd1, 8'd4, 1, 1);
        step(0, 0, 0, 1, 2'd3, 2'd1);
        exp_out("ill31", 16'h1842, 1, 8'd2, 8'd4, 1, 1, 1, 16'hBC2D);
        step(0, 0, 0, 1, 2'd2, 2'd2);
        exp_out("self22", 16'h1842, 1, 8'd2, 8'd4, 1, 1, 1, 16'hBC2D);

        for (int i = 0; i < 250; i++) step(0, 0, 0, 1, 2'd0, 2'd1);
        exp_out("sat_254", 16'h1842, 1, 8'd2, 8'd254, 1, 1);
        step(0, 0, 0, 1, 2'd0, 2'd1);
        exp_out("sat_255", 16'h1842, 1, 8'd2, 8'd255, 1, 1);
        for (int i = 0; i < 49; i++) step(0, 0, 0, 1, 2'd0, 2'd1);
        exp_out("sat_hold", 16'h1842, 1, 8'd2, 8'd255, 1, 1, 1, 16'h1111);

        step(0, 0, 1, 0, 2'd0, 2'd0);
        exp_out("clear", 16'h0, 0, 8'd0, 8'd0, 0, 0, 1, 16'h0);
        step(1, 0, 0, 0, 2'd0, 2'd0);
        exp_out("restart", 16'h0, 0, 8'd0, 8'd0, 0, 1);
        step(0, 1, 0, 1, 2'd0, 2'd1);
        exp_out("stop_with_sample", 16'h0002, 0, 8'd0, 8'd1, 0, 0, 1, 16'h0001);
        step(0, 0, 0, 1, 2'd1, 2'd2);
        exp_out("hold_ignores", 16'h0002, 0, 8'd0, 8'd1, 0, 0, 1, 16'h0001);
        step(1, 0, 0, 0, 2'd0, 2'd0);
        exp_out("resume", 16'h0002, 0, 8'd0, 8'd1, 0, 1);
        step(0, 0, 0, 1, 2'd1, 2'd2);
        exp_out("resume_t12", 16'h0042, 0, 8'd0, 8'd2, 0, 1, 1, 16'h0016);

        step(1, 1, 0, 0, 2'd0, 2'd0);
        exp_out("start_stop_run", 16'h0042, 0, 8'd0, 8'd2, 0, 0);
        step(1, 0, 0, 0, 2'd0, 2'd0);
        exp_out("resume2", 16'h0042, 0, 8'd0, 8'd2, 0, 1);
        step(0, 0, 1, 1, 2'd2, 2'd3);
        exp_out("clear_with_sample", 16'h0, 0, 8'd0, 8'd0, 0, 0, 1, 16'h0);

        step(1, 0, 0, 0, 2'd0, 2'd0);
        exp_out("start3", 16'h0, 0, 8'd0, 8'd0, 0, 1);
        step(0, 0, 0, 1, 2'd0, 2'd1);
        exp_out("pre_reset_t01", 16'h0002, 0, 8'd0, 8'd1, 0, 1, 1, 16'h0001);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        exp_out("async_reset", 16'h0, 0, 8'd0, 8'd0, 0, 0, 1, 16'h0);
        @(negedge clock);
        reset_n = 1'b1;
        step(0, 0, 0, 1, 2'd0, 2'd1);
        exp_out("post_reset_idle", 16'h0, 0, 8'd0, 8'd0, 0, 0, 1, 16'h0);

        wait_cycles = 0;
        while (sb_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clock);
            wait_cycles++;
        end
        n_total++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending, expected 0", sb_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
